conv_task_sequencer: RTL

Task-level controller for the generic convolution engine. It takes run-time parameter descriptors as a word stream into a shadow buffer. When the engine is idle it commits a complete descriptor onto the packed configuration bus. It then sequences the packer and MAC-array enables through setup, run and drain, and reports completion. The block sits between the host/DMA descriptor path and the configuration/enable inputs of the MAC array and packer.

---
 rtl/conv_task_sequencer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/conv_task_sequencer.sv
// conv_task_sequencer
// Task-level controller for the convolution engine. Descriptor words are
// streamed into a shadow buffer; when the engine is idle a complete
// descriptor is committed onto the packed cfg bus and the packer / MAC-array
// enables are sequenced through setup, run and drain.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   desc_data        32-bit descriptor word
//   desc_valid       word valid
//   desc_last        final word of a descriptor
//   desc_ready       word accept (combinational, ~shadow_full)
//   abort            synchronous abort request, highest priority
//   mac_done         MAC array finished (pulse or level)
//   packer_done      packer flushed (pulse or level)
//   cfg              committed descriptor, word k at bits [32k+31:32k]
//   cfg_vld          one-cycle pulse when cfg is updated
//   en_packer        packer enable
//   en_mac_array     MAC array enable
//   busy             sequencer not idle
//   task_done        one-cycle pulse on normal completion
//   err_len          one-cycle pulse on a malformed descriptor
//   err_timeout      sticky watchdog flag, cleared by the next commit
module conv_task_sequencer #(
  parameter int DESC_WORDS  = 16,
  parameter int SETUP_CYC   = 2,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             desc_data,
  input  logic                    desc_valid,
  input  logic                    desc_last,
  output logic                    desc_ready,
  input  logic                    abort,
  input  logic                    mac_done,
  input  logic                    packer_done,
  output logic [32*DESC_WORDS-1:0] cfg,
  output logic                    cfg_vld,
  output logic                    en_packer,
  output logic                    en_mac_array,
  output logic                    busy,
  output logic                    task_done,
  output logic                    err_len,
  output logic                    err_timeout
);

  localparam int WW = $clog2(DESC_WORDS);
  localparam int SW = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
  localparam logic [WW-1:0] LAST_IDX   = WW'(DESC_WORDS - 1);
  localparam logic [SW-1:0] SETUP_LAST = SW'(SETUP_CYC - 1);
  localparam logic [31:0]   WD_LAST    = 32'(TIMEOUT_CYC - 1);
  localparam bit            WD_EN      = (TIMEOUT_CYC > 0);

  typedef enum logic [1:0] {IDLE, RUN_SETUP, RUN, DRAIN} state_t;

  state_t                        state;
  logic [DESC_WORDS-1:0][31:0]   shadow;
  logic [WW-1:0]                 wcnt;
  logic                          shadow_full;
  logic                          dropping;
  logic                          mac_seen;
  logic                          pk_seen;
  logic [SW-1:0]                 setup_cnt;
  logic [31:0]                   wd_cnt;
  logic                          accept;
  logic                          shadow_we;
  logic                          wd_expire;

  // The loader stalls only while a complete descriptor waits for commit,
  // so a commit and a shadow write can never coincide.
  assign desc_ready = ~shadow_full;
  assign accept     = desc_valid & desc_ready;
  assign shadow_we  = accept & ~abort & ~dropping;
  // Watchdog fires on the TIMEOUT_CYC-th cycle spent in RUN/DRAIN.
  assign wd_expire  = WD_EN && ((state == RUN) || (state == DRAIN)) && (wd_cnt == WD_LAST);

  // Shadow storage carries no reset; its contents only matter once
  // shadow_full marks a complete descriptor.
  always_ff @(posedge clk) begin
    if (shadow_we) shadow[wcnt] <= desc_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cfg          <= '0;
      cfg_vld      <= 1'b0;
      en_packer    <= 1'b0;
      en_mac_array <= 1'b0;
      busy         <= 1'b0;
      task_done    <= 1'b0;
      err_len      <= 1'b0;
      err_timeout  <= 1'b0;
      wcnt         <= '0;
      shadow_full  <= 1'b0;
      dropping     <= 1'b0;
      mac_seen     <= 1'b0;
      pk_seen      <= 1'b0;
      setup_cnt    <= '0;
      wd_cnt       <= '0;
    end else begin
      cfg_vld   <= 1'b0;
      task_done <= 1'b0;
      err_len   <= 1'b0;
      if (abort) begin
        // Abort discards everything in flight, including a word offered
        // this cycle; cfg and err_timeout keep their values.
        state        <= IDLE;
        busy         <= 1'b0;
        en_packer    <= 1'b0;
        en_mac_array <= 1'b0;
        shadow_full  <= 1'b0;
        wcnt         <= '0;
        dropping     <= 1'b0;
        mac_seen     <= 1'b0;
        pk_seen      <= 1'b0;
      end else begin
        // Loader: an overlong descriptor flags once, then is swallowed up
        // to and including its last word.
        if (accept) begin
          if (dropping) begin
            if (desc_last) dropping <= 1'b0;
          end else if (desc_last) begin
            wcnt <= '0;
            if (wcnt == LAST_IDX) shadow_full <= 1'b1;
            else                  err_len     <= 1'b1;
          end else if (wcnt == LAST_IDX) begin
            wcnt     <= '0;
            dropping <= 1'b1;
            err_len  <= 1'b1;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end

        // Done inputs are latched so pulses arriving before the FSM
        // reaches the consuming state are not lost.
        if (state != IDLE) begin
          if (mac_done)    mac_seen <= 1'b1;
          if (packer_done) pk_seen  <= 1'b1;
        end
        if ((state == RUN) || (state == DRAIN)) wd_cnt <= wd_cnt + 32'd1;

        if (wd_expire) begin
          state        <= IDLE;
          busy         <= 1'b0;
          en_packer    <= 1'b0;
          en_mac_array <= 1'b0;
          err_timeout  <= 1'b1;
        end else begin
          case (state)
            IDLE: begin
              if (shadow_full) begin
                state       <= RUN_SETUP;
                cfg         <= shadow;
                shadow_full <= 1'b0;
                cfg_vld     <= 1'b1;
                en_packer   <= 1'b1;
                busy        <= 1'b1;
                setup_cnt   <= '0;
                wd_cnt      <= '0;
                err_timeout <= 1'b0;
                mac_seen    <= 1'b0;
                pk_seen     <= 1'b0;
              end
            end
            RUN_SETUP: begin
              if (setup_cnt == SETUP_LAST) begin
                state        <= RUN;
                en_mac_array <= 1'b1;
              end else begin
                setup_cnt <= setup_cnt + 1'b1;
              end
            end
            RUN: begin
              if (mac_seen) begin
                state        <= DRAIN;
                en_mac_array <= 1'b0;
              end
            end
            DRAIN: begin
              if (pk_seen) begin
                state     <= IDLE;
                busy      <= 1'b0;
                en_packer <= 1'b0;
                task_done <= 1'b1;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule
